mem_port_b_arbiter: RTL and testbench
=====================================

Name: mem_port_b_arbiter

Overview:
- Shares port B of the unified byte-write dual-port RAM between two requesters:
  - m0: core data/load-store path.
  - m1: secondary bus master, e.g. UART boot loader or DMA engine.
- Round-robin arbitration, with a bounded burst lock for m1.
- Routes the 1-cycle-latency read data back to the owning requester.
- Sits between the core/loader and the RAM port B address, write-enable and data pins.

Parameters:
- ADDR_WIDTH, 16, word address width driven to RAM port B.
- DATA_WIDTH, 32, data bus width.
- NB_COL, 4, byte-lane write-enable width.
- MAX_BURST, 8, maximum consecutive locked m1 grants while m0 is waiting (range 1..255).

Ports:
- clk_i  in  1  system clock; all state updates on rising edge.
- rst_n_i  in  1  reset; one clock; reset is asynchronous and active-low.
- m0_req_i  in  1  m0 access request; held with its fields stable until granted.
- m0_we_i  in  NB_COL  m0 byte write enables; all zero means read.
- m0_addr_i  in  ADDR_WIDTH  m0 word address.
- m0_wdata_i  in  DATA_WIDTH  m0 write data.
- m0_gnt_o  out  1  m0 request accepted this cycle (combinational).
- m0_rvalid_o  out  1  m0 response valid, one cycle after grant.
- m0_rdata_o  out  DATA_WIDTH  m0 read data, qualified by m0_rvalid_o.
- m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i, m1_gnt_o, m1_rvalid_o, m1_rdata_o: same as m0, for requester m1.
- m1_lock_i  in  1  m1 requests to keep ownership across consecutive accesses.
- mem_addr_o  out  ADDR_WIDTH  RAM port B address.
- mem_we_o  out  NB_COL  RAM port B byte write enables.
- mem_wdata_o  out  DATA_WIDTH  RAM port B write data.
- mem_rdata_i  in  DATA_WIDTH  RAM port B read data; valid one cycle after address.

Behaviour:
- State:
  - prio: which master has priority; 0 = m0, resets to 0.
  - owner_q: master granted last cycle; resets to 0.
  - pend_q: a response is due this cycle; resets to 0.
  - burst_cnt: 8-bit counter; resets to 0.
- Grant, combinational:
  - Only one master requests: that master is granted.
  - Both request: the master selected by prio is granted.
  - While rst_n_i is low, both gnt outputs are 0.
- Transfer: occurs in any cycle where req & gnt. The granted master's addr/we/wdata drive mem_* in the same cycle.
- No grant: mem_we_o = 0, mem_addr_o = 0, mem_wdata_o = 0. No spurious RAM writes are permitted.
- Priority update, on each transfer:
  - m0 granted: prio <= 1 and burst_cnt <= 0.
  - m1 granted with m1_lock_i = 0: prio <= 0 and burst_cnt <= 0.
  - m1 granted with m1_lock_i = 1: prio <= 1 and burst_cnt <= burst_cnt + 1 (saturating), but only if m0_req_i is high in that cycle; otherwise burst_cnt holds.
  - m1 granted, locked, and burst_cnt reaches MAX_BURST with m0_req_i high: prio <= 0, so m0 gets the next contended cycle. burst_cnt clears when m0 is granted.
- m1_lock_i deasserted: lock effect ends immediately; the normal round-robin rule applies on the next transfer.
- Response path:
  - On every transfer (read or write), pend_q <= 1 and owner_q <= granted master; otherwise pend_q <= 0.
  - mX_rvalid_o = pend_q & (owner_q == X), registered-state based, so rvalid asserts exactly 1 cycle after grant.
  - mX_rdata_o = mX_rvalid_o ? mem_rdata_i : 0.
  - For writes, the rdata content is the RAM's read-first old value; requesters ignore it.
- Throughput: one transfer per cycle. Back-to-back grants are allowed, including alternating masters. Each response goes only to its owner.
- Reset mid-operation:
  - All state clears asynchronously and any pending rvalid is dropped.
  - Outputs return to 0 while reset is asserted.
  - First grant after release uses prio = 0.
- Requesters must not change fields while req is high and ungranted. The arbiter does not register requests.

Test Plan:
- Single m0 read: m0_req=1, addr=0x0010, we=0 for 1 cycle → m0_gnt=1 same cycle, mem_addr_o=0x0010, mem_we_o=0; next cycle m0_rvalid=1 with m0_rdata=mem_rdata_i; m1_rvalid stays 0.
- Contention, no lock: both requesting continuously for 6 cycles after reset → grants alternate m0,m1,m0,m1,m0,m1; each rvalid lands 1 cycle after its own grant.
- Locked burst: m1_lock=1, both requesting, MAX_BURST=8 → m0 is granted once, then m1 gets exactly 8 consecutive grants, then m0 gets 1 grant, then the pattern repeats.
- Lock with m0 idle: m1_lock=1, only m1 requesting for 20 cycles → 20 consecutive m1 grants and burst_cnt stays 0; m0 then requests → m0 waits at most 8 cycles.
- Write path: m1 write addr=0x0200, we=4'b0011, wdata=0xDEADBEEF → mem_we_o=4'b0011 for that cycle only; m1_rvalid pulses next cycle; mem_we_o=0 on all idle cycles.
- Reset mid-transfer: assert rst_n_i low in the cycle after a grant → m0/m1_rvalid forced 0 immediately; after release, the first contended grant goes to m0.

Source files
------------

// File: rtl/mem_port_b_arbiter.sv
// mem_port_b_arbiter
//
// Shares port B of the byte-write dual-port RAM between two requesters:
//   m0 - core load/store path
//   m1 - secondary bus master (boot loader / DMA)
// Round-robin arbitration with a bounded burst lock for m1. The RAM has a
// one-cycle read latency, so the response (rvalid/rdata) is routed back to
// whichever master owned the port in the previous cycle.
//
// Ports:
//   clk_i, rst_n_i        clock, asynchronous active-low reset
//   mX_req_i              access request, fields held stable until granted
//   mX_we_i               byte write enables (all zero = read)
//   mX_addr_i/mX_wdata_i  word address / write data
//   mX_gnt_o              request accepted this cycle (combinational)
//   mX_rvalid_o/rdata_o   response one cycle after grant
//   m1_lock_i             m1 wants to keep ownership across accesses
//   mem_addr_o/we_o/wdata_o  RAM port B request pins
//   mem_rdata_i           RAM port B read data (one cycle after address)

module mem_port_b_arbiter #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NB_COL     = 4,
    parameter int unsigned MAX_BURST  = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,

    input  logic                  m0_req_i,
    input  logic [NB_COL-1:0]     m0_we_i,
    input  logic [ADDR_WIDTH-1:0] m0_addr_i,
    input  logic [DATA_WIDTH-1:0] m0_wdata_i,
    output logic                  m0_gnt_o,
    output logic                  m0_rvalid_o,
    output logic [DATA_WIDTH-1:0] m0_rdata_o,

    input  logic                  m1_req_i,
    input  logic [NB_COL-1:0]     m1_we_i,
    input  logic [ADDR_WIDTH-1:0] m1_addr_i,
    input  logic [DATA_WIDTH-1:0] m1_wdata_i,
    input  logic                  m1_lock_i,
    output logic                  m1_gnt_o,
    output logic                  m1_rvalid_o,
    output logic [DATA_WIDTH-1:0] m1_rdata_o,

    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [NB_COL-1:0]     mem_we_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    localparam logic [7:0] BurstLimit = 8'(MAX_BURST);

    logic       prio_q, prio_d;       // 0 = m0 wins contention, 1 = m1 wins
    logic       owner_q, owner_d;     // master that owned the port last cycle
    logic       pend_q, pend_d;       // a response is due this cycle
    logic [7:0] burst_cnt_q, burst_cnt_d;
    logic [7:0] burst_inc;
    logic       gnt0, gnt1;

    // Grant decode; gated by reset so nothing leaks out while held in reset.
    always_comb begin
        gnt0 = rst_n_i & m0_req_i & (~m1_req_i | ~prio_q);
        gnt1 = rst_n_i & m1_req_i & (~m0_req_i | prio_q);
    end

    assign m0_gnt_o = gnt0;
    assign m1_gnt_o = gnt1;

    // Request mux; idle cycles drive zeros so the RAM never sees a stray write.
    always_comb begin
        mem_addr_o  = '0;
        mem_we_o    = '0;
        mem_wdata_o = '0;
        if (gnt0) begin
            mem_addr_o  = m0_addr_i;
            mem_we_o    = m0_we_i;
            mem_wdata_o = m0_wdata_i;
        end else if (gnt1) begin
            mem_addr_o  = m1_addr_i;
            mem_we_o    = m1_we_i;
            mem_wdata_o = m1_wdata_i;
        end
    end

    always_comb begin
        burst_inc = (burst_cnt_q == 8'hFF) ? 8'hFF : burst_cnt_q + 8'd1;
    end

    always_comb begin
        prio_d      = prio_q;
        owner_d     = owner_q;
        burst_cnt_d = burst_cnt_q;
        pend_d      = 1'b0;
        if (gnt0) begin
            pend_d      = 1'b1;
            owner_d     = 1'b0;
            prio_d      = 1'b1;
            burst_cnt_d = 8'd0;
        end else if (gnt1) begin
            pend_d  = 1'b1;
            owner_d = 1'b1;
            if (!m1_lock_i) begin
                prio_d      = 1'b0;
                burst_cnt_d = 8'd0;
            end else begin
                prio_d = 1'b1;
                // The burst only counts while m0 is actually being held off.
                if (m0_req_i) begin
                    burst_cnt_d = burst_inc;
                    if (burst_inc >= BurstLimit) begin
                        prio_d = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            prio_q      <= 1'b0;
            owner_q     <= 1'b0;
            pend_q      <= 1'b0;
            burst_cnt_q <= 8'd0;
        end else begin
            prio_q      <= prio_d;
            owner_q     <= owner_d;
            pend_q      <= pend_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    assign m0_rvalid_o = pend_q & ~owner_q;
    assign m1_rvalid_o = pend_q & owner_q;
    assign m0_rdata_o  = m0_rvalid_o ? mem_rdata_i : '0;
    assign m1_rdata_o  = m1_rvalid_o ? mem_rdata_i : '0;

endmodule

// File: tb/tb_mem_port_b_arbiter.sv
// Testbench for mem_port_b_arbiter: directed scenarios with literal
// expectations plus a randomized phase, all checked every cycle against a
// behavioural arbitration model.

module tb_mem_port_b_arbiter;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 32;
    localparam int unsigned NC = 4;
    localparam int unsigned MB = 8;

    logic          clk_i = 1'b0;
    logic          rst_n_i;
    logic          m0_req_i, m1_req_i, m1_lock_i;
    logic [NC-1:0] m0_we_i, m1_we_i;
    logic [AW-1:0] m0_addr_i, m1_addr_i;
    logic [DW-1:0] m0_wdata_i, m1_wdata_i;
    logic          m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o;
    logic [DW-1:0] m0_rdata_o, m1_rdata_o;
    logic [AW-1:0] mem_addr_o;
    logic [NC-1:0] mem_we_o;
    logic [DW-1:0] mem_wdata_o;
    logic [DW-1:0] mem_rdata_i;

    mem_port_b_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NB_COL     (NC),
        .MAX_BURST  (MB)
    ) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .m0_req_i    (m0_req_i),
        .m0_we_i     (m0_we_i),
        .m0_addr_i   (m0_addr_i),
        .m0_wdata_i  (m0_wdata_i),
        .m0_gnt_o    (m0_gnt_o),
        .m0_rvalid_o (m0_rvalid_o),
        .m0_rdata_o  (m0_rdata_o),
        .m1_req_i    (m1_req_i),
        .m1_we_i     (m1_we_i),
        .m1_addr_i   (m1_addr_i),
        .m1_wdata_i  (m1_wdata_i),
        .m1_lock_i   (m1_lock_i),
        .m1_gnt_o    (m1_gnt_o),
        .m1_rvalid_o (m1_rvalid_o),
        .m1_rdata_o  (m1_rdata_o),
        .mem_addr_o  (mem_addr_o),
        .mem_we_o    (mem_we_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Whose turn it is under contention, how many locked m1 grants have been
    // taken while m0 waited, and which master (1 = m0, 2 = m1) is owed a
    // response this cycle (0 = none).
    int m_turn    = 1;
    int m_streak  = 0;
    int m_due     = 0;

    function automatic int winner();
        if (rst_n_i !== 1'b1) return 0;
        if (m0_req_i && m1_req_i) return m_turn;
        if (m0_req_i) return 1;
        if (m1_req_i) return 2;
        return 0;
    endfunction

    always @(posedge clk_i or negedge rst_n_i) begin
        int w;
        int s;
        if (!rst_n_i) begin
            m_turn   <= 1;
            m_streak <= 0;
            m_due    <= 0;
        end else begin
            w = winner();
            m_due <= w;
            if (w == 1) begin
                m_turn   <= 2;
                m_streak <= 0;
            end else if (w == 2 && !m1_lock_i) begin
                m_turn   <= 1;
                m_streak <= 0;
            end else if (w == 2) begin
                s = m_streak;
                if (m0_req_i) s = (s + 1 > 255) ? 255 : s + 1;
                m_streak <= s;
                m_turn   <= (m0_req_i && s >= int'(MB)) ? 1 : 2;
            end
        end
    end

    // Compare process: all outputs are stable at the falling edge.
    always @(negedge clk_i) begin
        int w;
        logic [AW-1:0] e_addr;
        logic [NC-1:0] e_we;
        logic [DW-1:0] e_wd;
        w = winner();
        e_addr = (w == 1) ? m0_addr_i : (w == 2) ? m1_addr_i : '0;
        e_we   = (w == 1) ? m0_we_i : (w == 2) ? m1_we_i : '0;
        e_wd   = (w == 1) ? m0_wdata_i : (w == 2) ? m1_wdata_i : '0;
        check("model_gnt0", 64'(m0_gnt_o), 64'(w == 1));
        check("model_gnt1", 64'(m1_gnt_o), 64'(w == 2));
        check("model_addr", 64'(mem_addr_o), 64'(e_addr));
        check("model_we", 64'(mem_we_o), 64'(e_we));
        check("model_wdata", 64'(mem_wdata_o), 64'(e_wd));
        check("model_rvalid0", 64'(m0_rvalid_o), 64'(m_due == 1));
        check("model_rvalid1", 64'(m1_rvalid_o), 64'(m_due == 2));
        check("model_rdata0", 64'(m0_rdata_o), 64'((m_due == 1) ? mem_rdata_i : '0));
        check("model_rdata1", 64'(m1_rdata_o), 64'((m_due == 2) ? mem_rdata_i : '0));
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        m0_req_i = 1'b0; m0_we_i = '0; m0_addr_i = '0; m0_wdata_i = '0;
        m1_req_i = 1'b0; m1_we_i = '0; m1_addr_i = '0; m1_wdata_i = '0;
        m1_lock_i = 1'b0;
    endtask

    task automatic do_reset();
        tick();
        rst_n_i = 1'b0;
        idle_inputs();
        m0_req_i = 1'b1;
        m1_req_i = 1'b1;
        #1;
        check("reset_gnt0", 64'(m0_gnt_o), 64'd0);
        check("reset_gnt1", 64'(m1_gnt_o), 64'd0);
        check("reset_rvalid", 64'({m0_rvalid_o, m1_rvalid_o}), 64'd0);
        tick();
        idle_inputs();
        tick();
        rst_n_i = 1'b1;
    endtask

    initial begin
        int cnt;
        int waited;
        int w_last;
        rst_n_i     = 1'b1;
        idle_inputs();
        mem_rdata_i = '0;
        #2 rst_n_i  = 1'b0;
        #20;
        tick();
        rst_n_i = 1'b1;

        // Single m0 read.
        do_reset();
        tick();
        m0_req_i = 1'b1; m0_addr_i = 16'h0010;
        #1;
        check("rd_gnt0", 64'(m0_gnt_o), 64'd1);
        check("rd_addr", 64'(mem_addr_o), 64'h10);
        check("rd_we", 64'(mem_we_o), 64'd0);
        tick();
        m0_req_i = 1'b0;
        mem_rdata_i = 32'hCAFE0001;
        #1;
        check("rd_rvalid0", 64'(m0_rvalid_o), 64'd1);
        check("rd_rdata0", 64'(m0_rdata_o), 64'hCAFE0001);
        check("rd_rvalid1", 64'(m1_rvalid_o), 64'd0);

        // Unlocked contention alternates m0, m1, ...
        do_reset();
        for (int i = 0; i < 6; i++) begin
            tick();
            m0_req_i = 1'b1; m1_req_i = 1'b1;
            #1;
            check("alt_gnt1", 64'(m1_gnt_o), 64'(i % 2));
            if (i > 0) check("alt_rvalid1", 64'(m1_rvalid_o), 64'((i - 1) % 2));
        end

        // Locked burst: m0 once, then MB m1 grants, repeating.
        do_reset();
        for (int i = 0; i < 19; i++) begin
            tick();
            m0_req_i = 1'b1; m1_req_i = 1'b1; m1_lock_i = 1'b1;
            #1;
            check("burst_gnt1", 64'(m1_gnt_o), 64'((i % 9) != 0));
        end

        // Locked m1 alone does not build up a burst count.
        do_reset();
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            m1_req_i = 1'b1; m1_lock_i = 1'b1;
            #1;
            if (m1_gnt_o) cnt++;
        end
        check("solo_m1_grants", 64'(cnt), 64'd20);
        waited = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            m0_req_i = 1'b1;
            #1;
            if (m0_gnt_o) break;
            waited++;
        end
        check("m0_wait_cycles", 64'(waited), 64'd8);
        tick();
        idle_inputs();

        // m1 byte write.
        do_reset();
        tick();
        m1_req_i = 1'b1; m1_we_i = 4'b0011; m1_addr_i = 16'h0200; m1_wdata_i = 32'hDEADBEEF;
        #1;
        check("wr_gnt1", 64'(m1_gnt_o), 64'd1);
        check("wr_we", 64'(mem_we_o), 64'h3);
        check("wr_addr", 64'(mem_addr_o), 64'h200);
        check("wr_wdata", 64'(mem_wdata_o), 64'hDEADBEEF);
        tick();
        idle_inputs();
        mem_rdata_i = 32'h12345678;
        #1;
        check("wr_idle_we", 64'(mem_we_o), 64'd0);
        check("wr_rvalid1", 64'(m1_rvalid_o), 64'd1);
        check("wr_rdata1", 64'(m1_rdata_o), 64'h12345678);
        check("wr_rvalid0", 64'(m0_rvalid_o), 64'd0);

        // Reset while a response is pending.
        do_reset();
        tick();
        m0_req_i = 1'b1; m0_addr_i = 16'h0040;
        tick();
        m0_req_i = 1'b0; m1_req_i = 1'b1;
        #1;
        check("mid_pend_rvalid0", 64'(m0_rvalid_o), 64'd1);
        rst_n_i = 1'b0;
        #1;
        check("mid_rst_rvalid0", 64'(m0_rvalid_o), 64'd0);
        check("mid_rst_gnt1", 64'(m1_gnt_o), 64'd0);
        check("mid_rst_we", 64'(mem_we_o), 64'd0);
        tick();
        rst_n_i = 1'b1;
        m0_req_i = 1'b1; m1_req_i = 1'b1;
        #1;
        check("post_rst_gnt0", 64'(m0_gnt_o), 64'd1);
        check("post_rst_gnt1", 64'(m1_gnt_o), 64'd0);
        tick();
        idle_inputs();

        // Randomized traffic honouring the hold-until-granted rule.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk_i);
            w_last = winner();
            tick();
            mem_rdata_i = $urandom;
            if (!rst_n_i) begin
                rst_n_i = 1'b1;
            end else if ($urandom_range(0, 299) == 0) begin
                rst_n_i = 1'b0;
            end
            if (!m0_req_i || w_last == 1) begin
                m0_req_i   = ($urandom_range(0, 9) < 6);
                m0_we_i    = ($urandom_range(0, 1) == 0) ? '0 : NC'($urandom);
                m0_addr_i  = AW'($urandom);
                m0_wdata_i = $urandom;
            end
            if (!m1_req_i || w_last == 2) begin
                m1_req_i   = ($urandom_range(0, 9) < 7);
                m1_we_i    = ($urandom_range(0, 1) == 0) ? '0 : NC'($urandom);
                m1_addr_i  = AW'($urandom);
                m1_wdata_i = $urandom;
            end
            if ($urandom_range(0, 15) == 0) m1_lock_i = ~m1_lock_i;
        end

        tick();
        idle_inputs();
        @(negedge clk_i);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
